uart_rx_engine: RTL
===================

Name: uart_rx_engine

Overview:
- Parametrised, synthesizable UART receive engine for the UART block.
- Oversamples rxd, deserialises frames with configurable width, parity and stop bits, and flags framing, parity, break and overrun errors.
- Buffers received characters in a FIFO and raises an interrupt at a fill threshold.
- Drives the rxd/intrpt side of the UART signal bundle inside the DUT-side model and the SoC integration.

Parameters:
- DATA_BITS, 8: character width, legal 5..9.
- OVERSAMPLE, 16: ticks per bit, even, legal 8..32.
- FIFO_DEPTH, 16: RX FIFO entries, power of 2, legal 2..256.
- DIV_W, 16: width of baud_div.
- RX_THRESH, 8: intrpt asserts when fifo_count >= RX_THRESH; legal 1..FIFO_DEPTH.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- baud_div  in  DIV_W  clock cycles per oversample tick; 0 is treated as 1.
- parity_mode  in  2  0 none, 1 even, 2 odd, 3 treated as none.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- rxd  in  1  serial input, asynchronous.
- rd_en  in  1  pop FIFO head.
- rd_data  out  DATA_BITS  FIFO head (show-ahead).
- rd_perr  out  1  parity error flag stored with head entry.
- rd_ferr  out  1  framing error flag stored with head entry.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overrun  out  1  one-cycle pulse: character dropped.
- break_det  out  1  one-cycle pulse: break detected.
- intrpt  out  1  level, fifo_count >= RX_THRESH.

Behaviour:
- Reset values:
  - all outputs 0 and FIFO emptied;
  - synchroniser flops = 1; FSM = IDLE; tick counter = 0.
  - Reset asserted mid-frame aborts the frame with no push.
- rxd synchronisation: 2-flop synchroniser; rxd_s is the second stage. Latency is 2 cycles.
- Tick generator:
  - free-running down-counter reloads to max(baud_div,1)-1 and emits tick when it reaches 0.
  - Restarts from reload on the IDLE->START transition.
- Config latching: parity_mode and stop_bits are latched on the IDLE->START transition. Mid-frame changes do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE: rxd_s == 0 -> START, sample counter = 0.
  - START: at tick count OVERSAMPLE/2, sample rxd_s.
    - 1: false start, go to IDLE with no push and no flags.
    - 0: go to DATA.
  - DATA: sample every OVERSAMPLE ticks (bit centre), LSB first. After DATA_BITS samples go to PARITY if parity is enabled, else STOP1.
  - PARITY: sample once. Error when even and XOR(data, p) = 1, or odd and XOR(data, p) = 0.
  - STOP1: sample once; 0 = framing error.
    - Break: data all 0, parity bit 0 (if enabled) and stop bit 0. Pulse break_det, push nothing, go to BRK_WAIT.
    - Otherwise go to STOP2 if stop_bits = 1; else push and go to IDLE.
  - STOP2: sample; 0 = framing error. Then push and go to IDLE.
  - BRK_WAIT: stay until rxd_s == 1, then IDLE.
- Push timing: push happens in the cycle of the final stop-bit sample. The entry is {perr, ferr, data}.
- FIFO:
  - Push is accepted if count < FIFO_DEPTH, or if rd_en && rd_valid in the same cycle. Otherwise the character is dropped and overrun pulses.
  - rd_en when empty is ignored.
  - Simultaneous push and pop on a non-full FIFO leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_data, rd_perr and rd_ferr update the cycle after a pop.
- intrpt is combinational from the registered count.

Decomposition:
- Package uart_rx_pkg:
  - parity_mode_e (NONE, EVEN, ODD);
  - rx_state_e;
  - rx_entry_t struct builder, parametrised via DATA_BITS in the module.
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO with the push-when-full-with-pop rule, count output and overrun indication.

Test Plan:
- Clean 8N1 frame: baud_div=4, OVERSAMPLE=16, no parity, stop_bits=0, send 0x55 -> exactly one push, rd_data=0x55, rd_perr=0, rd_ferr=0, fifo_count=1, intrpt=0.
- Parity: send 0xA3 with parity_mode=1 and a deliberately wrong parity bit (p=1) -> rd_data=0xA3, rd_perr=1. Repeat with parity_mode=2 and p=1 -> rd_perr=0.
- Framing and break:
  - 0x3C with stop bit held low in 8N2 (second stop low) -> rd_ferr=1, pushed.
  - rxd held low for 20 bit times -> break_det pulses once, no push, FSM returns to IDLE after rxd goes high.
- Overrun: FIFO_DEPTH=4, send 5 characters without rd_en -> fifo_count=4, overrun pulses on the 5th. Repeat with rd_en asserted in the 5th push cycle -> no overrun, count stays 4.
- False start and glitch: 3-cycle low pulse on rxd (shorter than OVERSAMPLE/2 ticks) -> no push, no flags.
- Reset in DATA state: assert reset mid-frame -> count=0, all outputs 0. The next clean frame 0x7E is received correctly.
- Interrupt threshold: RX_THRESH=2 -> intrpt rises on the 2nd push and falls on the pop that leaves count=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive engine.
// Parity rules and the per-entry error flags live here so the engine and any checker agree.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_PARITY   = 3'd3,
      ST_STOP1    = 3'd4,
      ST_STOP2    = 3'd5,
      ST_BRK_WAIT = 3'd6
   } rx_state_e;

   typedef struct packed {
      logic perr;
      logic ferr;
   } rx_flags_t;

   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // data_xor is the XOR of all received data bits; mode 3 behaves as no parity.
   function automatic logic par_error(input logic [1:0] mode, input logic data_xor,
                                      input logic par_bit);
      case (mode)
         PAR_EVEN: return data_xor ^ par_bit;
         PAR_ODD:  return ~(data_xor ^ par_bit);
         default:  return 1'b0;
      endcase
   endfunction

   function automatic rx_flags_t make_flags(input logic perr, input logic ferr);
      rx_flags_t f;
      f.perr = perr;
      f.ferr = ferr;
      return f;
   endfunction

endpackage

// File: rtl/uart_rx_engine_fifo.sv
// Synchronous show-ahead FIFO for received characters.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overrun_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overrun_q;
   logic             pop_s;
   logic             accept_s;

   always_comb begin
      pop_s    = pop_i && (count_q != {CNT_W{1'b0}});
      accept_s = push_i && ((count_q < CNT_W'(DEPTH)) || pop_s);
   end

   always_ff @(posedge clk_i) begin
      if (accept_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q  <= {PTR_W{1'b0}};
         rd_ptr_q  <= {PTR_W{1'b0}};
         count_q   <= {CNT_W{1'b0}};
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push_i && !accept_s;
         if (accept_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({accept_s, pop_s})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      if (count_q != {CNT_W{1'b0}}) begin
         head_o = mem_q[rd_ptr_q];
      end else begin
         head_o = {WIDTH{1'b0}};
      end
      valid_o   = (count_q != {CNT_W{1'b0}});
      count_o   = count_q;
      overrun_o = overrun_q;
   end

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: synchronises rxd, deframes characters with optional parity
// and one or two stop bits, detects break, and queues {perr, ferr, data} in a FIFO.
module uart_rx_engine
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   parameter int RX_THRESH  = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop_bits,
   input  logic                          rxd,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_perr,
   output logic                          rd_ferr,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          break_det,
   output logic                          intrpt
);
   localparam int SAMP_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SAMP_W-1:0] HALF_M1  = SAMP_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SAMP_W-1:0] FULL_M1  = SAMP_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

   typedef struct packed {
      rx_flags_t              flags;
      logic [DATA_BITS-1:0]   data;
   } rx_entry_t;

   logic [1:0]            sync_q;
   logic                  rxd_s;
   logic [DIV_W-1:0]      tick_cnt_q;
   logic [DIV_W-1:0]      tick_cnt_d;
   logic [DIV_W-1:0]      reload_s;
   logic                  tick_s;
   logic                  start_s;

   rx_state_e             state_q;
   logic [SAMP_W-1:0]     samp_q;
   logic [BIT_W-1:0]      bit_cnt_q;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  par_acc_q;
   logic                  par_bit_q;
   logic                  perr_q;
   logic                  ferr_q;
   logic [1:0]            pm_q;
   logic                  sb_q;
   logic                  break_q;

   logic                  samp_done_s;
   logic                  data_zero_s;
   logic                  brk_s;
   logic                  push_s;
   logic                  ferr_s;
   logic                  ovr_s;
   rx_entry_t             entry_s;
   rx_entry_t             head_s;
   logic [CNT_W-1:0]      count_s;

   assign rxd_s = sync_q[1];

   // Tick reload and restart; a zero divider behaves like one.
   always_comb begin
      if (baud_div == {DIV_W{1'b0}}) begin
         reload_s = {DIV_W{1'b0}};
      end else begin
         reload_s = baud_div - DIV_W'(1);
      end
      start_s = (state_q == ST_IDLE) && !rxd_s;
      tick_s  = (tick_cnt_q == {DIV_W{1'b0}});
      if (start_s || tick_s) begin
         tick_cnt_d = reload_s;
      end else begin
         tick_cnt_d = tick_cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q     <= 2'b11;
         tick_cnt_q <= {DIV_W{1'b0}};
      end else begin
         sync_q     <= {sync_q[0], rxd};
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // Stop-bit decisions are combinational so the push lands on the final sample edge.
   always_comb begin
      samp_done_s = tick_s && (samp_q == ((state_q == ST_START) ? HALF_M1 : FULL_M1));
      data_zero_s = (shift_q == {DATA_BITS{1'b0}});
      push_s      = 1'b0;
      brk_s       = 1'b0;
      ferr_s      = ferr_q;
      if (samp_done_s && (state_q == ST_STOP1)) begin
         ferr_s = ~rxd_s;
         if (!rxd_s && data_zero_s && !(par_enabled(pm_q) && par_bit_q)) begin
            brk_s = 1'b1;
         end else if (!sb_q) begin
            push_s = 1'b1;
         end else begin
            push_s = 1'b0;
         end
      end else if (samp_done_s && (state_q == ST_STOP2)) begin
         ferr_s = ferr_q | ~rxd_s;
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      entry_s.flags = make_flags(perr_q, ferr_s);
      entry_s.data  = shift_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         samp_q    <= {SAMP_W{1'b0}};
         bit_cnt_q <= {BIT_W{1'b0}};
         shift_q   <= {DATA_BITS{1'b0}};
         par_acc_q <= 1'b0;
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         pm_q      <= 2'b00;
         sb_q      <= 1'b0;
         break_q   <= 1'b0;
      end else begin
         break_q <= brk_s;
         case (state_q)
            ST_IDLE: begin
               if (!rxd_s) begin
                  state_q   <= ST_START;
                  samp_q    <= {SAMP_W{1'b0}};
                  pm_q      <= parity_mode;
                  sb_q      <= stop_bits;
                  par_acc_q <= 1'b0;
                  par_bit_q <= 1'b0;
                  perr_q    <= 1'b0;
                  ferr_q    <= 1'b0;
               end
            end
            ST_START: begin
               if (samp_done_s) begin
                  samp_q    <= {SAMP_W{1'b0}};
                  bit_cnt_q <= {BIT_W{1'b0}};
                  state_q   <= rxd_s ? ST_IDLE : ST_DATA;
               end else if (tick_s) begin
                  samp_q <= samp_q + SAMP_W'(1);
               end
            end
            ST_DATA: begin
               if (samp_done_s) begin
                  samp_q    <= {SAMP_W{1'b0}};
                  shift_q   <= {rxd_s, shift_q[DATA_BITS-1:1]};
                  par_acc_q <= par_acc_q ^ rxd_s;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= par_enabled(pm_q) ? ST_PARITY : ST_STOP1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                  end
               end else if (tick_s) begin
                  samp_q <= samp_q + SAMP_W'(1);
               end
            end
            ST_PARITY: begin
               if (samp_done_s) begin
                  samp_q    <= {SAMP_W{1'b0}};
                  par_bit_q <= rxd_s;
                  perr_q    <= par_error(pm_q, par_acc_q, rxd_s);
                  state_q   <= ST_STOP1;
               end else if (tick_s) begin
                  samp_q <= samp_q + SAMP_W'(1);
               end
            end
            ST_STOP1: begin
               if (samp_done_s) begin
                  samp_q <= {SAMP_W{1'b0}};
                  ferr_q <= ferr_s;
                  if (brk_s) begin
                     state_q <= ST_BRK_WAIT;
                  end else if (sb_q) begin
                     state_q <= ST_STOP2;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (tick_s) begin
                  samp_q <= samp_q + SAMP_W'(1);
               end
            end
            ST_STOP2: begin
               if (samp_done_s) begin
                  samp_q  <= {SAMP_W{1'b0}};
                  state_q <= ST_IDLE;
               end else if (tick_s) begin
                  samp_q <= samp_q + SAMP_W'(1);
               end
            end
            ST_BRK_WAIT: begin
               if (rxd_s) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clock),
      .reset_i   (reset),
      .push_i    (push_s),
      .data_i    (entry_s),
      .pop_i     (rd_en),
      .head_o    (head_s),
      .valid_o   (rd_valid),
      .count_o   (count_s),
      .overrun_o (ovr_s)
   );

   always_comb begin
      rd_data    = head_s.data;
      rd_perr    = head_s.flags.perr;
      rd_ferr    = head_s.flags.ferr;
      fifo_count = count_s;
      overrun    = ovr_s;
      break_det  = break_q;
      intrpt     = (count_s >= CNT_W'(RX_THRESH));
   end

endmodule
